// File: rtl/lcd_seg_pkg.sv
// Shared 7-segment definitions for the LCD counter: segment bit positions,
// digit patterns and the BCD-to-segment decoder.
package lcd_seg_pkg;

  localparam int SEG_A = 0;
  localparam int SEG_B = 1;
  localparam int SEG_C = 2;
  localparam int SEG_D = 3;
  localparam int SEG_E_BIT = 4;
  localparam int SEG_F = 5;
  localparam int SEG_G = 6;

  localparam logic [6:0] M_A = 7'(1) << SEG_A;
  localparam logic [6:0] M_B = 7'(1) << SEG_B;
  localparam logic [6:0] M_C = 7'(1) << SEG_C;
  localparam logic [6:0] M_D = 7'(1) << SEG_D;
  localparam logic [6:0] M_E = 7'(1) << SEG_E_BIT;
  localparam logic [6:0] M_F = 7'(1) << SEG_F;
  localparam logic [6:0] M_G = 7'(1) << SEG_G;

  localparam logic [6:0] SEG_0     = M_A | M_B | M_C | M_D | M_E | M_F;
  localparam logic [6:0] SEG_1     = M_B | M_C;
  localparam logic [6:0] SEG_2     = M_A | M_B | M_D | M_E | M_G;
  localparam logic [6:0] SEG_3     = M_A | M_B | M_C | M_D | M_G;
  localparam logic [6:0] SEG_4     = M_B | M_C | M_F | M_G;
  localparam logic [6:0] SEG_5     = M_A | M_C | M_D | M_F | M_G;
  localparam logic [6:0] SEG_6     = M_A | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG_7     = M_A | M_B | M_C;
  localparam logic [6:0] SEG_8     = M_A | M_B | M_C | M_D | M_E | M_F | M_G;
  localparam logic [6:0] SEG_9     = M_A | M_B | M_C | M_D | M_F | M_G;
  localparam logic [6:0] SEG_BLANK = 7'b0000000;
  localparam logic [6:0] SEG_E     = M_A | M_D | M_E | M_F | M_G;

  function automatic logic [6:0] bcd_to_seg7(input logic [3:0] bcd);
    case (bcd)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_E;
    endcase
  endfunction

endpackage

// File: rtl/bcd_digit_updown.sv
// One decimal up/down digit with synchronous load and a combinational
// carry/borrow output that enables the next digit in the chain.
module bcd_digit_updown (
  input  logic       clk,
  input  logic       rst,
  input  logic       en,
  input  logic       up,
  input  logic       load,
  input  logic [3:0] load_d,
  output logic [3:0] d,
  output logic       cout
);

  assign cout = en & (up ? (d == 4'd9) : (d == 4'd0));

  // NOTE: registers use <= so every digit samples its neighbours' old values at the same edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      d <= 4'd0;
    end else if (load) begin
      d <= (load_d > 4'd9) ? 4'd0 : load_d;
    end else if (en) begin
      if (up) d <= (d == 4'd9) ? 4'd0 : d + 4'd1;
      else    d <= (d == 4'd0) ? 4'd9 : d - 4'd1;
    end
  end

endmodule

// File: rtl/lcd_bcd_counter_n.sv
// N-digit BCD up/down counter with AC-driven static 7-segment LCD outputs;
// step and common-electrode rates come from clock-enable prescalers.
module lcd_bcd_counter_n
  import lcd_seg_pkg::*;
#(
  parameter int DIGITS   = 4,
  parameter int STEP_DIV = 2048,
  parameter int COM_DIV  = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  run,
  input  logic                  up,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_val,
  input  logic                  blank_lz,
  output logic [4*DIGITS-1:0]   digits,
  output logic                  wrap,
  output logic                  load_err,
  output logic                  lcdcom,
  output logic [7*DIGITS-1:0]   lcdseg
);

  localparam int SW = $clog2(STEP_DIV);
  localparam int CW = $clog2(COM_DIV);

  logic [SW-1:0]       step_cnt;
  logic [CW-1:0]       com_cnt;
  logic                step_tick;
  logic                com_tick;
  logic                lcdcom_next;
  logic [DIGITS-1:0]   dig_en;
  logic [DIGITS-1:0]   cout;
  logic [DIGITS-1:0]   bad_digit;
  logic [7*DIGITS-1:0] seg_pat;
  logic                above_zero;

  assign step_tick   = run && (step_cnt == SW'(STEP_DIV - 1));
  assign com_tick    = (com_cnt == CW'(COM_DIV - 1));
  assign lcdcom_next = lcdcom ^ com_tick;

  for (genvar i = 0; i < DIGITS; i++) begin : g_digit
    if (i == 0) begin : g_lsd
      assign dig_en[i] = step_tick;
    end else begin : g_chain
      assign dig_en[i] = cout[i-1];
    end

    assign bad_digit[i] = (load_val[4*i +: 4] > 4'd9);

    bcd_digit_updown u_digit (
      .clk    (clk),
      .rst    (rst),
      .en     (dig_en[i]),
      .up     (up),
      .load   (load),
      .load_d (load_val[4*i +: 4]),
      .d      (digits[4*i +: 4]),
      .cout   (cout[i])
    );
  end

  // Scan from the most significant digit down so above_zero means "this and all higher are 0".
  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    above_zero = 1'b1;
    seg_pat    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      above_zero = above_zero && (digits[4*i +: 4] == 4'd0);
      if (blank_lz && above_zero && (i > 0))
        seg_pat[7*i +: 7] = SEG_BLANK;
      else
        seg_pat[7*i +: 7] = bcd_to_seg7(digits[4*i +: 4]);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      step_cnt <= '0;
      com_cnt  <= '0;
      lcdcom   <= 1'b0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      lcdseg   <= '0;
    end else begin
      step_cnt <= (!run || step_tick) ? '0 : step_cnt + SW'(1);
      com_cnt  <= com_tick ? '0 : com_cnt + CW'(1);
      lcdcom   <= lcdcom_next;
      // A load discards the coincident step, so its carry must not report a wrap.
      wrap     <= cout[DIGITS-1] & ~load;
      if (load) load_err <= |bad_digit;
      lcdseg   <= seg_pat ^ {(7*DIGITS){lcdcom_next}};
    end
  end

endmodule
